csm_arbiter: RTL
================

Name: csm_arbiter

Overview:
- Two-requester access arbiter for the shared CSM memory, sitting between the port A/B masters and the CSM enable/hold/release controls.
- Decides which port owns CSM each cycle, using round-robin fairness, a burst limit, and hold/lock semantics with a watchdog timeout.
- Reports per-port error codes to the masters.

Parameters:
MAX_BURST, 8, max consecutive unlocked grant cycles while the other port is waiting (>=1)
HOLD_TIMEOUT, 64, max cycles a port may stay in lock before forced release (>=2)
CNT_W, 7, counter width; must hold max(MAX_BURST, HOLD_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
a_enable  in  1  port A requests access
a_hold  in  1  port A requests exclusive lock (sampled only while A owns)
a_release  in  1  port A ends its lock (single-cycle pulse)
b_enable  in  1  port B requests access
b_hold  in  1  port B requests exclusive lock
b_release  in  1  port B ends its lock
a_grant  out  1  A owns CSM this cycle (registered)
b_grant  out  1  B owns CSM this cycle (registered)
a_err  out  2  A status: 00 ok, 01 busy/waiting, 10 locked out, 11 protocol violation
b_err  out  2  B status, same encoding
owner  out  2  00 none, 01 A, 10 B (registered)
timeout  out  1  one-cycle pulse when a lock is forcibly broken

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0; burst_cnt=0; hold_cnt=0.
  - last_owner=B, so A wins the first tie.
- States: IDLE, GRANT_A, GRANT_B, LOCK_A, LOCK_B. The grant/owner outputs decode from state. All outputs are registered.
- IDLE:
  - Only A enable -> GRANT_A next cycle; only B -> GRANT_B.
  - Both -> grant the port != last_owner.
  - Grant latency from enable rise is exactly 1 cycle.
- Entering GRANT_x or LOCK_x sets last_owner=x.
- GRANT_x:
  - burst_cnt increments each cycle the other port's enable is high; it clears whenever the other port's enable is low.
  - x_enable low and x_hold low -> switch directly to GRANT_y if y_enable is high, else go to IDLE.
  - x_hold high (with x_enable high) -> LOCK_x; hold_cnt=0.
  - burst_cnt reaches MAX_BURST, y_enable high, and x_hold low -> preempt to GRANT_y.
  - Hold wins over preemption in the same cycle.
- LOCK_x:
  - Stays in LOCK_x regardless of x_enable. hold_cnt increments each cycle.
  - x_release -> GRANT_y if y_enable, else IDLE.
  - hold_cnt == HOLD_TIMEOUT-1 without release -> forced exit (same destination as release).
  - On forced exit: timeout=1 for one cycle and x_err=11 for one cycle.
- Errors, combinational inputs registered to outputs, 1-cycle delay:
  - Non-owner with enable high while other port is in GRANT -> 01.
  - Non-owner with enable high while other port is in LOCK -> 10.
  - Any port asserting release while not in its own LOCK -> 11, release ignored.
  - hold asserted by a non-owner is ignored (no error).
  - Otherwise 00.
- Simultaneous events:
  - Owner release plus other port's enable in the same cycle -> handoff with no IDLE bubble.
  - a_enable and b_enable rising in the same cycle from IDLE -> round-robin decides.
  - Owner enable drop in the same cycle burst expires -> normal switch, no preempt flag.
- Mutual exclusion invariant: a_grant & b_grant is never 1.
- Reset mid-lock: immediate return to IDLE, no timeout pulse, counters cleared.

Test Plan:
- Reset, then a_enable=1 at cycle 2 -> a_grant=1, owner=01 at cycle 3; b_err=00 throughout.
- Both enable together from IDLE after reset -> A granted. A drops enable -> B granted next cycle. Both re-request from IDLE -> A granted (last_owner=B).
- A holds enable continuously and B requests -> b_err=01, and after 8 cycles of B waiting, b_grant=1 and a_grant=0 the next cycle.
- A in GRANT_A asserts a_hold -> LOCK_A; B enable -> b_err=10; a_release pulse -> b_grant=1 the next cycle, b_err=00.
- A locks with no release -> after 64 lock cycles, timeout pulses 1 cycle, a_err=11 for 1 cycle, state returns to IDLE (or GRANT_B if b_enable high).
- b_release pulse while in IDLE -> b_err=11 for one cycle, state unchanged. Assert reset during LOCK_A -> all outputs 0 immediately, timeout stays 0.

Source files
------------

// File: rtl/csm_arbiter_if.sv
// Handshake bundle between the port A/B masters and the CSM access arbiter.
// The arbiter takes the slave modport; the masters (or a bench) take the master modport.
interface csm_arbiter_if;
    logic       a_enable;
    logic       a_hold;
    logic       a_release;
    logic       b_enable;
    logic       b_hold;
    logic       b_release;
    logic       a_grant;
    logic       b_grant;
    logic [1:0] a_err;
    logic [1:0] b_err;
    logic [1:0] owner;
    logic       timeout;

    modport slave (
        input  a_enable, a_hold, a_release,
        input  b_enable, b_hold, b_release,
        output a_grant, b_grant, a_err, b_err, owner, timeout
    );

    modport master (
        output a_enable, a_hold, a_release,
        output b_enable, b_hold, b_release,
        input  a_grant, b_grant, a_err, b_err, owner, timeout
    );
endinterface

// File: rtl/csm_arbiter.sv
// Two-port CSM ownership arbiter: round-robin ties, burst-limited preemption,
// exclusive locks broken by a watchdog, and per-port status codes.
module csm_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int HOLD_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic          clk,
    input  logic          reset,
    csm_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_A = 3'd1,
        GRANT_B = 3'd2,
        LOCK_A  = 3'd3,
        LOCK_B  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             last_owner_q, last_owner_d;   // 0 = A, 1 = B
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       a_err_q, a_err_d;
    logic [1:0]       b_err_q, b_err_d;
    logic             timeout_q, timeout_d;
    logic             a_forced, b_forced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            a_err_q      <= 2'b00;
            b_err_q      <= 2'b00;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            a_err_q      <= a_err_d;
            b_err_q      <= b_err_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        a_forced    = 1'b0;
        b_forced    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.a_enable && bus.b_enable)
                    state_d = last_owner_q ? GRANT_A : GRANT_B;
                else if (bus.a_enable)
                    state_d = GRANT_A;
                else if (bus.b_enable)
                    state_d = GRANT_B;
            end
            GRANT_A: begin
                burst_cnt_d = bus.b_enable ? burst_cnt_q + 1'b1 : '0;
                // Lock beats drop/preempt; a drop beats preemption in the same cycle.
                if (bus.a_enable && bus.a_hold)
                    state_d = LOCK_A;
                else if (!bus.a_enable)
                    state_d = bus.b_enable ? GRANT_B : IDLE;
                else if (bus.b_enable && burst_cnt_q >= BURST_LAST)
                    state_d = GRANT_B;
            end
            GRANT_B: begin
                burst_cnt_d = bus.a_enable ? burst_cnt_q + 1'b1 : '0;
                if (bus.b_enable && bus.b_hold)
                    state_d = LOCK_B;
                else if (!bus.b_enable)
                    state_d = bus.a_enable ? GRANT_A : IDLE;
                else if (bus.a_enable && burst_cnt_q >= BURST_LAST)
                    state_d = GRANT_A;
            end
            LOCK_A: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (bus.a_release) begin
                    state_d = bus.b_enable ? GRANT_B : IDLE;
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d  = bus.b_enable ? GRANT_B : IDLE;
                    a_forced = 1'b1;
                end
            end
            LOCK_B: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (bus.b_release) begin
                    state_d = bus.a_enable ? GRANT_A : IDLE;
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d  = bus.a_enable ? GRANT_A : IDLE;
                    b_forced = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every change of state starts both counters afresh.
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            hold_cnt_d  = '0;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        case (state_d)
            GRANT_A, LOCK_A: last_owner_d = 1'b0;
            GRANT_B, LOCK_B: last_owner_d = 1'b1;
            default:         last_owner_d = last_owner_q;
        endcase
    end

    always_comb begin
        a_err_d   = 2'b00;
        b_err_d   = 2'b00;
        timeout_d = a_forced | b_forced;

        if ((bus.a_release && state_q != LOCK_A) || a_forced)
            a_err_d = 2'b11;
        else if (bus.a_enable && state_q == GRANT_B)
            a_err_d = 2'b01;
        else if (bus.a_enable && state_q == LOCK_B)
            a_err_d = 2'b10;

        if ((bus.b_release && state_q != LOCK_B) || b_forced)
            b_err_d = 2'b11;
        else if (bus.b_enable && state_q == GRANT_A)
            b_err_d = 2'b01;
        else if (bus.b_enable && state_q == LOCK_A)
            b_err_d = 2'b10;
    end

    assign bus.a_grant = (state_q == GRANT_A) || (state_q == LOCK_A);
    assign bus.b_grant = (state_q == GRANT_B) || (state_q == LOCK_B);
    assign bus.owner   = {bus.b_grant, bus.a_grant};
    assign bus.a_err   = a_err_q;
    assign bus.b_err   = b_err_q;
    assign bus.timeout = timeout_q;
endmodule
